pbs_ctrl: RTL and testbench

- Turn-sequencing FSM for the battle simulator. Drives the battle datapath's control inputs (trainer select, RNG stop, HP load, damage apply) and consumes its outputs (player HP, AI HP, damage, accuracy).
- Runs one full round per player confirm press: player attack first, then AI attack. Handles accuracy resolution, KO detection, turn counting and game over.

---
 rtl/pbs_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pbs_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbs_ctrl.sv
// pbs_ctrl: turn sequencer for the battle simulator datapath.
// Optional macro PBS_CTRL_MISS_EN enables the accuracy check and miss output.
module pbs_ctrl #(
  parameter int TURN_W    = 4,
  parameter int MAX_TURNS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [3:0]        p_hp,
  input  logic [3:0]        ai_hp,
  input  logic [3:0]        dmg,
  input  logic [3:0]        accu,
  input  logic [3:0]        acc_roll,
  output logic              actr,
  output logic              target,
  output logic              stop,
  output logic              load_ai_hp,
  output logic              app_pl_dmg,
  output logic              app_ai_dmg,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              miss,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam logic [TURN_W-1:0] MAX_T = TURN_W'(MAX_TURNS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_P_SEL,
    S_P_SETTLE,
    S_P_RES,
    S_AI_SEL,
    S_AI_SETTLE,
    S_AI_RES,
    S_END,
    S_OVER
  } state_t;

  state_t            state_q, state_d;
  logic              go_q, arm_q;
  logic              actr_q, actr_d;
  logic              target_q, target_d;
  logic              stop_q, stop_d;
  logic              load_q, load_d;
  logic              apl_q, apl_d;
  logic              aai_q, aai_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [TURN_W-1:0] turn_inc;
  logic              miss_q, miss_d;
  logic              over_q, over_d;
  logic [1:0]        win_q, win_d;
  logic              go_rise;
  logic              hit;

  // arm_q blocks a start from a go level that was already high out of reset
  assign go_rise  = go & ~go_q & arm_q;
  assign turn_inc = (turn_q >= MAX_T) ? turn_q : turn_q + 1'b1;

`ifdef PBS_CTRL_MISS_EN
  assign hit  = (acc_roll <= accu);
  assign miss = miss_q;
`else
  logic unused_acc;
  assign unused_acc = ^{acc_roll, accu, miss_q};
  assign hit  = 1'b1;
  assign miss = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    actr_d   = actr_q;
    target_d = target_q;
    aai_d    = 1'b0;
    apl_d    = 1'b0;
    turn_d   = turn_q;
    miss_d   = miss_q;
    win_d    = win_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_rise) state_d = S_P_SEL;
      end
      S_P_SEL:    state_d = S_P_SETTLE;
      S_P_SETTLE: state_d = S_P_RES;
      S_P_RES: begin
        miss_d = ~hit;
        if (!hit) begin
          state_d = S_AI_SEL;
        end else if (dmg >= ai_hp) begin
          win_d   = 2'b01;
          state_d = S_OVER;
        end else begin
          aai_d   = 1'b1;
          state_d = S_AI_SEL;
        end
      end
      S_AI_SEL:    state_d = S_AI_SETTLE;
      S_AI_SETTLE: state_d = S_AI_RES;
      S_AI_RES: begin
        miss_d = ~hit;
        if (hit && dmg >= p_hp) begin
          win_d   = 2'b10;
          state_d = S_OVER;
        end else begin
          apl_d   = hit;
          state_d = S_END;
        end
      end
      S_END: begin
        turn_d = turn_inc;
        if (turn_inc == MAX_T) begin
          win_d   = 2'b11;
          state_d = S_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OVER: state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
    // level outputs follow the state being entered, so they are glitch-free
    if (state_d == S_P_SEL) begin
      actr_d   = 1'b0;
      target_d = 1'b1;
    end else if (state_d == S_AI_SEL) begin
      actr_d   = 1'b1;
      target_d = 1'b0;
    end
    stop_d = state_d inside {S_P_SETTLE, S_P_RES,
                             S_AI_SETTLE, S_AI_RES};
    load_d = (state_d == S_P_SETTLE);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      arm_q    <= 1'b0;
      actr_q   <= 1'b0;
      target_q <= 1'b1;
      stop_q   <= 1'b0;
      load_q   <= 1'b0;
      apl_q    <= 1'b0;
      aai_q    <= 1'b0;
      turn_q   <= '0;
      miss_q   <= 1'b0;
      over_q   <= 1'b0;
      win_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      go_q     <= go;
      arm_q    <= arm_q | ~go;
      actr_q   <= actr_d;
      target_q <= target_d;
      stop_q   <= stop_d;
      load_q   <= load_d;
      apl_q    <= apl_d;
      aai_q    <= aai_d;
      turn_q   <= turn_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
      win_q    <= win_d;
    end
  end

  assign actr       = actr_q;
  assign target     = target_q;
  assign stop       = stop_q;
  assign load_ai_hp = load_q;
  assign app_pl_dmg = apl_q;
  assign app_ai_dmg = aai_q;
  assign turn_cnt   = turn_q;
  assign game_over  = over_q;
  assign winner     = win_q;

endmodule

// File: tb/tb_pbs_ctrl.sv
// tb_pbs_ctrl: scoreboard bench for the pbs_ctrl turn sequencer.
// Events: 1 ai dmg, 2 pl dmg, 3 game over (winner), 4 turn count up.
module tb_pbs_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       go  = 1'b0;
  logic [3:0] p_hp = 4'd15;
  logic [3:0] ai_hp = 4'd15;
  logic [3:0] dmg = 4'd3;
  logic [3:0] accu = 4'd15;
  logic [3:0] acc_roll = 4'd0;
  logic       actr, target, stop, load_ai_hp;
  logic       app_pl_dmg, app_ai_dmg;
  logic [3:0] turn_cnt;
  logic       miss, game_over;
  logic [1:0] winner;

  pbs_ctrl #(.TURN_W(4), .MAX_TURNS(2)) dut (
    .clk(clk), .rst(rst), .go(go),
    .p_hp(p_hp), .ai_hp(ai_hp), .dmg(dmg),
    .accu(accu), .acc_roll(acc_roll),
    .actr(actr), .target(target), .stop(stop),
    .load_ai_hp(load_ai_hp),
    .app_pl_dmg(app_pl_dmg), .app_ai_dmg(app_ai_dmg),
    .turn_cnt(turn_cnt), .miss(miss),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input int k, input int c, input int d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input int k, input int d);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_ev kind=%0d cyc=%0d data=%0d exp=none",
               k, cyc, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.data != d) begin
        bad++;
        $display("FAIL event act=k%0d/c%0d/d%0d exp=k%0d/c%0d/d%0d",
                 k, cyc, d, e.kind, e.cyc, e.data);
      end
    end
  endtask

  int   tc_prev = 0;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (app_ai_dmg) chk_ev(1, int'(miss));
      if (app_pl_dmg) chk_ev(2, int'(miss));
      if (int'(turn_cnt) > tc_prev) chk_ev(4, int'(turn_cnt));
      if (game_over && !ov_prev) chk_ev(3, int'(winner));
      check("pulse_excl", int'(app_ai_dmg & app_pl_dmg), 0);
    end
    tc_prev <= int'(turn_cnt);
    ov_prev <= game_over;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    go  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic round_start(output int c);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    c = cyc;
  endtask

  initial begin
    int c;
    // reset held with go high
    rst = 1'b0;
    go  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_actr", int'(actr), 0);
    check("rst_target", int'(target), 1);
    check("rst_stop", int'(stop), 0);
    check("rst_load", int'(load_ai_hp), 0);
    check("rst_aai", int'(app_ai_dmg), 0);
    check("rst_apl", int'(app_pl_dmg), 0);
    check("rst_turn", int'(turn_cnt), 0);
    check("rst_miss", int'(miss), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_win", int'(winner), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("nostart_stop", int'(stop), 0);
    check("nostart_load", int'(load_ai_hp), 0);

    // normal round
    round_start(c);
    push(1, c + 4, 0);
    push(2, c + 7, 0);
    push(4, c + 8, 1);
    repeat (2) @(negedge clk);
    check("p_settle_load", int'(load_ai_hp), 1);
    @(negedge clk);
    check("p_res_stop", int'(stop), 1);
    check("p_res_actr", int'(actr), 0);
    check("p_res_target", int'(target), 1);
    repeat (3) @(negedge clk);
    check("ai_res_actr", int'(actr), 1);
    check("ai_res_target", int'(target), 0);
    check("ai_res_stop", int'(stop), 1);
    repeat (4) @(negedge clk);
    check("normal_over", int'(game_over), 0);

    // player KO, then go edges ignored
    do_reset();
    ai_hp = 4'd3;
    dmg   = 4'd3;
    round_start(c);
    push(3, c + 4, 1);
    repeat (8) @(negedge clk);
    round_start(c);
    repeat (10) @(negedge clk);
    check("pko_over", int'(game_over), 1);
    check("pko_win", int'(winner), 1);
    check("pko_turn", int'(turn_cnt), 0);

    // AI HP already 0, zero damage still KOs
    do_reset();
    ai_hp = 4'd0;
    dmg   = 4'd0;
    round_start(c);
    push(3, c + 4, 1);
    repeat (8) @(negedge clk);

    // low accuracy roll
    do_reset();
    ai_hp    = 4'd15;
    p_hp     = 4'd15;
    dmg      = 4'd3;
    accu     = 4'd4;
    acc_roll = 4'd9;
    round_start(c);
`ifdef PBS_CTRL_MISS_EN
    push(4, c + 8, 1);
    repeat (10) @(negedge clk);
    check("miss_flag", int'(miss), 1);
`else
    push(1, c + 4, 0);
    push(2, c + 7, 0);
    push(4, c + 8, 1);
    repeat (10) @(negedge clk);
    check("miss_flag", int'(miss), 0);
`endif
    accu     = 4'd15;
    acc_roll = 4'd0;

    // AI KO
    do_reset();
    p_hp = 4'd2;
    dmg  = 4'd5;
    round_start(c);
    push(1, c + 4, 0);
    push(3, c + 7, 2);
    repeat (10) @(negedge clk);
    check("aiko_turn", int'(turn_cnt), 0);

    // draw after MAX_TURNS=2 rounds
    do_reset();
    p_hp = 4'd15;
    dmg  = 4'd0;
    round_start(c);
    push(1, c + 4, 0);
    push(2, c + 7, 0);
    push(4, c + 8, 1);
    repeat (9) @(negedge clk);
    round_start(c);
    push(1, c + 4, 0);
    push(2, c + 7, 0);
    push(4, c + 8, 2);
    push(3, c + 8, 3);
    repeat (10) @(negedge clk);
    check("draw_win", int'(winner), 3);
    check("draw_turn", int'(turn_cnt), 2);
    check("draw_over", int'(game_over), 1);

    // reset lands while in P_RES
    do_reset();
    dmg = 4'd3;
    round_start(c);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_aai", int'(app_ai_dmg), 0);
    check("midrst_stop", int'(stop), 0);
    check("midrst_target", int'(target), 1);
    check("midrst_turn", int'(turn_cnt), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_idle_stop", int'(stop), 0);

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
